// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA window fetch stage.
package vga_pkg;
    localparam int WIN_X0    = 192;
    localparam int WIN_Y0    = 135;
    localparam int WIN_W     = 256;
    localparam int WIN_H     = 240;
    localparam int V_SWAP    = 480;
    localparam int ADDR_W    = 17;
    localparam int PIX_W     = 3;
    localparam int WIN_SHIFT = $clog2(WIN_W);
    localparam int BANK_SIZE = WIN_W * WIN_H;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } swap_state_t;

    // Base RAM address of a frame-buffer bank (bank 1 starts after bank 0).
    function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
        return bank ? ADDR_W'(BANK_SIZE) : '0;
    endfunction
endpackage

// File: rtl/vga_bank_swap_ctrl.sv
// Front/back bank swap FSM. A pending swap commits only at the scan
// position (0, V_SWAP) on a pixel-enable clock, so the displayed bank never
// changes mid-frame. Drawer writes are only accepted while the FSM is IDLE.
//
// Handshakes: wr_req and swap_req are levels held by the drawer until the
// matching one-clock ack pulse; a request counts as taken on the clock its
// ack is high, and the drawer may drop or change it on the following clock.
module vga_bank_swap_ctrl
    import vga_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_pix_en,
    input  logic [9:0] i_counter_x,
    input  logic [9:0] i_counter_y,
    input  logic       i_swap_req,
    input  logic       i_wr_req,
    input  logic       i_wr_ack,
    output logic       o_swap_ack,
    output logic       o_front_bank,
    output logic       o_wr_accept,
    output logic [1:0] o_state
);

    swap_state_t r_state;
    logic        r_swap_ack;
    logic        r_front_bank;
    logic        w_commit;

    assign w_commit = i_pix_en && (i_counter_y == 10'(V_SWAP)) && (i_counter_x == 10'd0);

    // Swap state machine with registered ack pulse and front-bank register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_swap_ack   <= 1'b0;
            r_front_bank <= 1'b0;
        end else begin
            r_swap_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_swap_req) r_state <= PEND;
                end
                PEND: begin
                    if (w_commit) begin
                        r_front_bank <= ~r_front_bank;
                        r_swap_ack   <= 1'b1;
                        r_state      <= ACK;
                    end
                end
                ACK: begin
                    if (!i_swap_req) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A write is taken only in IDLE and never on the clock its ack is out,
    // which limits writes to one every two clocks.
    assign o_wr_accept  = i_wr_req && !i_wr_ack && (r_state == IDLE);
    assign o_swap_ack   = r_swap_ack;
    assign o_front_bank = r_front_bank;
    assign o_state      = r_state;

endmodule

// File: rtl/vga_window_fetch.sv
// Maps the scan position inside the 256x240 window to a frame-buffer read
// address, returns the fetched pixel to the VGA pins with sync aligned (two
// pixel-enable latency), and owns the drawer write port into the back bank.
module vga_window_fetch
    import vga_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_pix_en,
    input  logic [9:0]        i_counter_x,
    input  logic [9:0]        i_counter_y,
    input  logic              i_in_display,
    input  logic              i_hsync_in,
    input  logic              i_vsync_in,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [PIX_W-1:0]  i_rd_data,
    input  logic              i_wr_req,
    input  logic [7:0]        i_wr_x,
    input  logic [7:0]        i_wr_y,
    input  logic [PIX_W-1:0]  i_wr_rgb,
    output logic              o_wr_ack,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [PIX_W-1:0]  o_wr_data,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic              o_front_bank,
    output logic              o_vga_r,
    output logic              o_vga_g,
    output logic              o_vga_b,
    output logic              o_vga_hsync,
    output logic              o_vga_vsync
);

    logic              w_front_bank;
    logic              w_wr_accept;
    logic [1:0]        w_swap_state;
    logic              w_in_win;
    logic [9:0]        w_dx;
    logic [9:0]        w_dy;
    logic [ADDR_W-1:0] w_rd_addr_next;
    logic              w_wr_in_range;
    logic [ADDR_W-1:0] w_wr_addr_next;

    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_s1_win;
    logic              r_s1_hsync;
    logic              r_s1_vsync;
    logic              r_vga_r;
    logic              r_vga_g;
    logic              r_vga_b;
    logic              r_vga_hsync;
    logic              r_vga_vsync;
    logic              r_wr_ack;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    pixel_t            r_wr_data;

    vga_bank_swap_ctrl u_swap (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_pix_en     (i_pix_en),
        .i_counter_x  (i_counter_x),
        .i_counter_y  (i_counter_y),
        .i_swap_req   (i_swap_req),
        .i_wr_req     (i_wr_req),
        .i_wr_ack     (r_wr_ack),
        .o_swap_ack   (o_swap_ack),
        .o_front_bank (w_front_bank),
        .o_wr_accept  (w_wr_accept),
        .o_state      (w_swap_state)
    );

    // Window hit test and read address; the row stride is a shift by WIN_SHIFT.
    assign w_in_win = i_in_display
                   && (i_counter_x >= 10'(WIN_X0)) && (i_counter_x < 10'(WIN_X0 + WIN_W))
                   && (i_counter_y >= 10'(WIN_Y0)) && (i_counter_y < 10'(WIN_Y0 + WIN_H));
    assign w_dx = i_counter_x - 10'(WIN_X0);
    assign w_dy = i_counter_y - 10'(WIN_Y0);
    assign w_rd_addr_next = bank_base(w_front_bank)
                          + (ADDR_W'(w_dy) << WIN_SHIFT)
                          + ADDR_W'(w_dx);

    // Drawer writes always target the bank not being displayed.
    assign w_wr_in_range  = (i_wr_y < 8'(WIN_H));
    assign w_wr_addr_next = bank_base(~w_front_bank)
                          + (ADDR_W'(i_wr_y) << WIN_SHIFT)
                          + ADDR_W'(i_wr_x);

    // Stage 1: issue the RAM read and carry window flag and raw syncs.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_rd_addr  <= '0;
            r_s1_win   <= 1'b0;
            r_s1_hsync <= 1'b1;
            r_s1_vsync <= 1'b1;
        end else if (i_pix_en) begin
            if (w_in_win) r_rd_addr <= w_rd_addr_next;
            r_s1_win   <= w_in_win;
            r_s1_hsync <= i_hsync_in;
            r_s1_vsync <= i_vsync_in;
        end
    end

    // Stage 2: the RAM data is ready by the next pixel enable; blank outside the window.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_vga_r     <= 1'b0;
            r_vga_g     <= 1'b0;
            r_vga_b     <= 1'b0;
            r_vga_hsync <= 1'b1;
            r_vga_vsync <= 1'b1;
        end else if (i_pix_en) begin
            r_vga_r     <= r_s1_win & i_rd_data[0];
            r_vga_g     <= r_s1_win & i_rd_data[1];
            r_vga_b     <= r_s1_win & i_rd_data[2];
            r_vga_hsync <= r_s1_hsync;
            r_vga_vsync <= r_s1_vsync;
        end
    end

    // Write port: ack every accepted request, strobe the RAM only for rows in range.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wr_ack  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_ack <= w_wr_accept;
            r_wr_en  <= w_wr_accept && w_wr_in_range;
            if (w_wr_accept) begin
                r_wr_data <= i_wr_rgb;
                if (w_wr_in_range) r_wr_addr <= w_wr_addr_next;
            end
        end
    end

    assign o_rd_addr    = r_rd_addr;
    assign o_front_bank = w_front_bank;
    assign o_vga_r      = r_vga_r;
    assign o_vga_g      = r_vga_g;
    assign o_vga_b      = r_vga_b;
    assign o_vga_hsync  = r_vga_hsync;
    assign o_vga_vsync  = r_vga_vsync;
    assign o_wr_ack     = r_wr_ack;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;

endmodule

// File: tb/tb_vga_window_fetch.sv
// Directed bench for vga_window_fetch: read pipeline, write port and bank swap.
module tb_vga_window_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  counter_x = '0;
    logic [9:0]  counter_y = '0;
    logic        in_display = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [16:0] rd_addr;
    logic [2:0]  rd_data = '0;
    logic        wr_req = 1'b0;
    logic [7:0]  wr_x = '0;
    logic [7:0]  wr_y = '0;
    logic [2:0]  wr_rgb = '0;
    logic        wr_ack;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [2:0]  wr_data;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        front_bank;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;
    logic        vga_hsync;
    logic        vga_vsync;

    int checks = 0;
    int failures = 0;

    vga_window_fetch dut (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_pix_en     (pix_en),
        .i_counter_x  (counter_x),
        .i_counter_y  (counter_y),
        .i_in_display (in_display),
        .i_hsync_in   (hsync_in),
        .i_vsync_in   (vsync_in),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .i_wr_req     (wr_req),
        .i_wr_x       (wr_x),
        .i_wr_y       (wr_y),
        .i_wr_rgb     (wr_rgb),
        .o_wr_ack     (wr_ack),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .i_swap_req   (swap_req),
        .o_swap_ack   (swap_ack),
        .o_front_bank (front_bank),
        .o_vga_r      (vga_r),
        .o_vga_g      (vga_g),
        .o_vga_b      (vga_b),
        .o_vga_hsync  (vga_hsync),
        .o_vga_vsync  (vga_vsync)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pixel-enable clock at the given scan position, then one idle clock.
    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic disp,
                       input logic hs, input logic vs);
        counter_x  = x;
        counter_y  = y;
        in_display = disp;
        hsync_in   = hs;
        vsync_in   = vs;
        pix_en     = 1'b1;
        @(negedge clock);
        pix_en     = 1'b0;
        @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_rd_addr"},    32'(rd_addr),    32'd0);
        chk({pfx, "_wr_en"},      32'(wr_en),      32'd0);
        chk({pfx, "_wr_addr"},    32'(wr_addr),    32'd0);
        chk({pfx, "_wr_data"},    32'(wr_data),    32'd0);
        chk({pfx, "_wr_ack"},     32'(wr_ack),     32'd0);
        chk({pfx, "_swap_ack"},   32'(swap_ack),   32'd0);
        chk({pfx, "_front_bank"}, 32'(front_bank), 32'd0);
        chk({pfx, "_rgb"},        32'({vga_b, vga_g, vga_r}), 32'd0);
        chk({pfx, "_hsync"},      32'(vga_hsync),  32'd1);
        chk({pfx, "_vsync"},      32'(vga_vsync),  32'd1);
    endtask

    initial begin
        // Reset
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clock);

        // Read pipeline: first window pixel, RGB and hsync appear two pix_en later
        rd_data = 3'b101;
        pix(10'd192, 10'd135, 1'b1, 1'b0, 1'b1);
        chk("first_rd_addr", 32'(rd_addr), 32'd0);
        chk("rgb_not_early", 32'({vga_b, vga_g, vga_r}), 32'd0);
        chk("hsync_not_early", 32'(vga_hsync), 32'd1);
        pix(10'd193, 10'd135, 1'b1, 1'b1, 1'b1);
        chk("vga_r", 32'(vga_r), 32'd1);
        chk("vga_g", 32'(vga_g), 32'd0);
        chk("vga_b", 32'(vga_b), 32'd1);
        chk("hsync_delayed", 32'(vga_hsync), 32'd0);
        chk("addr_next_col", 32'(rd_addr), 32'd1);

        // Last window pixel
        pix(10'd447, 10'd374, 1'b1, 1'b1, 1'b0);
        chk("last_rd_addr", 32'(rd_addr), 32'd61439);
        chk("hsync_back_high", 32'(vga_hsync), 32'd1);

        // Just outside the window: address held, pixels blanked
        pix(10'd191, 10'd135, 1'b1, 1'b1, 1'b1);
        chk("left_out_addr_hold", 32'(rd_addr), 32'd61439);
        chk("vsync_delayed", 32'(vga_vsync), 32'd0);
        pix(10'd448, 10'd200, 1'b1, 1'b1, 1'b1);
        chk("right_out_addr_hold", 32'(rd_addr), 32'd61439);
        chk("left_out_rgb", 32'({vga_b, vga_g, vga_r}), 32'd0);
        pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        chk("right_out_rgb", 32'({vga_b, vga_g, vga_r}), 32'd0);

        // Write into back bank 1 while front is 0
        wr_x = 8'd3; wr_y = 8'd2; wr_rgb = 3'b010; wr_req = 1'b1;
        @(negedge clock);
        chk("wr_ack", 32'(wr_ack), 32'd1);
        chk("wr_en", 32'(wr_en), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'd61955);
        chk("wr_data", 32'(wr_data), 32'd2);
        wr_req = 1'b0;
        @(negedge clock);
        chk("wr_ack_one_clock", 32'(wr_ack), 32'd0);
        chk("wr_en_one_clock", 32'(wr_en), 32'd0);

        // Out-of-range row: acked but not written
        wr_x = 8'd5; wr_y = 8'd240; wr_rgb = 3'b111; wr_req = 1'b1;
        @(negedge clock);
        chk("drop_wr_ack", 32'(wr_ack), 32'd1);
        chk("drop_wr_en", 32'(wr_en), 32'd0);
        chk("drop_wr_data", 32'(wr_data), 32'd7);
        wr_req = 1'b0;
        @(negedge clock);

        // Swap requested mid-frame; a write held meanwhile waits
        swap_req = 1'b1;
        pix(10'd0, 10'd100, 1'b1, 1'b1, 1'b1);
        chk("pend_front", 32'(front_bank), 32'd0);
        chk("pend_swap_ack", 32'(swap_ack), 32'd0);
        wr_x = 8'd1; wr_y = 8'd1; wr_rgb = 3'b001; wr_req = 1'b1;
        @(negedge clock);
        chk("pend_wr_blocked_a", 32'(wr_ack), 32'd0);
        @(negedge clock);
        chk("pend_wr_blocked_b", 32'(wr_ack), 32'd0);
        pix(10'd0, 10'd479, 1'b0, 1'b1, 1'b1);
        chk("row479_front", 32'(front_bank), 32'd0);
        // Commit position without pixel enable: no commit
        counter_x = 10'd0; counter_y = 10'd480; pix_en = 1'b0;
        @(negedge clock);
        chk("no_en_front", 32'(front_bank), 32'd0);
        chk("no_en_wr_blocked", 32'(wr_ack), 32'd0);
        // Commit clock
        pix_en = 1'b1;
        @(negedge clock);
        pix_en = 1'b0;
        chk("commit_front", 32'(front_bank), 32'd1);
        chk("commit_swap_ack", 32'(swap_ack), 32'd1);
        chk("ack_wr_blocked", 32'(wr_ack), 32'd0);
        @(negedge clock);
        chk("swap_ack_one_clock", 32'(swap_ack), 32'd0);
        chk("ack_hold_wr_blocked", 32'(wr_ack), 32'd0);
        swap_req = 1'b0;
        @(negedge clock);
        chk("idle_return_wr", 32'(wr_ack), 32'd0);
        @(negedge clock);
        chk("held_wr_ack", 32'(wr_ack), 32'd1);
        chk("held_wr_en", 32'(wr_en), 32'd1);
        chk("held_wr_addr_bank0", 32'(wr_addr), 32'd257);
        wr_req = 1'b0;
        @(negedge clock);

        // Read from front bank 1
        pix(10'd200, 10'd140, 1'b1, 1'b1, 1'b1);
        chk("bank1_rd_addr", 32'(rd_addr), 32'd62728);
        chk("front_stays", 32'(front_bank), 32'd1);

        // Reset while a swap is pending
        swap_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        swap_req = 1'b0;
        @(negedge clock);
        chk_reset_outputs("pend_rst");
        reset_n = 1'b1;
        @(negedge clock);
        counter_x = 10'd0; counter_y = 10'd480; pix_en = 1'b1;
        @(negedge clock);
        pix_en = 1'b0;
        chk("abandon_swap_ack", 32'(swap_ack), 32'd0);
        chk("abandon_front", 32'(front_bank), 32'd0);
        @(negedge clock);

        // Request arriving on the commit clock waits for the next frame
        swap_req = 1'b1; pix_en = 1'b1;
        @(negedge clock);
        pix_en = 1'b0;
        chk("late_req_front", 32'(front_bank), 32'd0);
        chk("late_req_ack", 32'(swap_ack), 32'd0);
        @(negedge clock);
        pix_en = 1'b1;
        @(negedge clock);
        pix_en = 1'b0;
        chk("next_frame_front", 32'(front_bank), 32'd1);
        chk("next_frame_ack", 32'(swap_ack), 32'd1);
        swap_req = 1'b0;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_window_fetch.md
Name: vga_window_fetch

Overview:
- Video back-end stage directly downstream of the 640x480 sync generator; upstream of the VGA pins.
- Each pixel, maps the (x,y) scan position inside the 256x240 display window (x 192..447, y 135..374) to a double-buffered frame-buffer RAM address.
- Returns the 3-bit RGB pixel aligned with delayed H/V sync.
- Also owns the frame-buffer write port for the drawing logic and the front/back bank swap at frame boundary.

Parameters:
- WIN_X0, 192, window left column
- WIN_Y0, 135, window top row
- WIN_W, 256, window width (power of two; row stride)
- WIN_H, 240, window height
- V_SWAP, 480, scan row at which a pending swap commits
- ADDR_W, 17, RAM address width (holds 2*WIN_W*WIN_H = 122880)
- PIX_W, 3, bits per pixel {B,G,R}

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel-clock enable; never high on two consecutive clocks
- counter_x  in  10  scan column from sync generator
- counter_y  in  10  scan row from sync generator
- in_display  in  1  active-area flag
- hsync_in  in  1  raw horizontal sync
- vsync_in  in  1  raw vertical sync
- rd_addr  out  ADDR_W  RAM port A read address
- rd_data  in  PIX_W  RAM port A data; 1-clock synchronous read
- wr_req  in  1  drawer write request; held until wr_ack
- wr_x  in  8  write column (0..255)
- wr_y  in  8  write row
- wr_rgb  in  PIX_W  write pixel
- wr_ack  out  1  one-clock accept pulse
- wr_en  out  1  RAM port B write strobe
- wr_addr  out  ADDR_W  RAM port B address
- wr_data  out  PIX_W  RAM port B data
- swap_req  in  1  drawer frame-complete level; held until swap_ack
- swap_ack  out  1  one-clock pulse when swap commits
- front_bank  out  1  bank currently displayed
- vga_r  out  1  red pin
- vga_g  out  1  green pin
- vga_b  out  1  blue pin
- vga_hsync  out  1  horizontal sync pin
- vga_vsync  out  1  vertical sync pin

Behaviour:
- Clocking/reset: single clock `clock`; reset `reset_n` is synchronous, active-low. On reset:
  - rd_addr=0, wr_en=0, wr_addr=0, wr_data=0
  - wr_ack=0, swap_ack=0, front_bank=0
  - vga_r=vga_g=vga_b=0, vga_hsync=vga_vsync=1
  - FSM=IDLE, all pipeline valids cleared
- Video pipeline: advances only on clocks with pix_en=1.
  - Stage 1 (pix_en k): in_win = in_display && counter_x in [WIN_X0,WIN_X0+WIN_W) && counter_y in [WIN_Y0,WIN_Y0+WIN_H).
  - If in_win, register rd_addr = front_bank*WIN_W*WIN_H + (counter_y-WIN_Y0)*WIN_W + (counter_x-WIN_X0). The multiply by WIN_W is a shift; the subtractions are 10-bit, zero-extended to ADDR_W.
  - Outside the window, rd_addr holds its value.
  - Register in_win, hsync_in, vsync_in.
  - Stage 2 (pix_en k+1): vga_{r,g,b} = rd_data[0],[1],[2] gated by stage-1 in_win, else 0. vga_hsync/vsync = stage-1 copies.
  - Total latency: 2 pix_en for RGB and sync alike.
- Write path (back bank = ~front_bank):
  - A request is accepted on a clock where wr_req=1, wr_ack=0, FSM=IDLE.
  - On the next clock: wr_ack=1 and wr_data=wr_rgb. If wr_y<WIN_H, then wr_en=1 and wr_addr = back_base + wr_y*WIN_W + wr_x; otherwise wr_en=0 (request dropped, still acked).
  - Throughput: at most one write per 2 clocks.
  - No writes are accepted while FSM≠IDLE.
- Swap FSM:
  - IDLE: swap_req=1 → PEND.
  - PEND: on a clock with pix_en=1, counter_y==V_SWAP, counter_x==0 → toggle front_bank, go to ACK.
  - ACK: swap_ack=1 for exactly this clock; then wait for swap_req=0 → IDLE.
  - front_bank changes only at the commit point, never mid-active-frame.
  - A swap_req arriving at the commit clock itself commits at the next frame.
- Simultaneous wr_req and swap_req in IDLE: the write is accepted and the FSM enters PEND on the same clock.
- Reset asserted in PEND: the swap is abandoned and front_bank=0.

Decomposition:
- Package vga_pkg:
  - Window constants, BANK_SIZE = WIN_W*WIN_H, V_SWAP
  - typedef pixel_t (logic [PIX_W-1:0])
  - enum swap_state_t {IDLE, PEND, ACK}
- One sub-module, vga_bank_swap_ctrl: the swap FSM, front_bank register and write-accept gating.

Test Plan:
- Reset, front_bank=0, scan (192,135) → rd_addr=0; rd_data=3'b101 returned → vga_r=1, vga_g=0, vga_b=1 exactly 2 pix_en after the scan position; hsync delayed by 2 pix_en.
- Scan (447,374) → rd_addr=61439. Scan (191,135) and (448,200) → RGB=0, rd_addr unchanged.
- front_bank=1, scan (200,140) → rd_addr=62728.
- front_bank=0, wr_req with wr_x=3, wr_y=2, wr_rgb=3'b010 → next clock wr_ack=1, wr_en=1, wr_addr=61955, wr_data=3'b010. wr_y=240 → wr_ack=1, wr_en=0.
- swap_req raised at row 100 → front_bank toggles only at (0,480) with pix_en; swap_ack one clock; a wr_req held during PEND is not acked until IDLE.
- reset_n low during PEND → front_bank=0, swap_ack never pulses, all outputs at reset values on the next clock.
